fetch_queue: RTL



---
 rtl/fetch_queue_if.sv | 39 +++
 rtl/fetch_queue.sv | 99 +++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue_if
//  Brief    : Fetch-stage bus bundle: instruction memory, decode handshake,
//             redirect and occupancy.
//  Revision : 1.0
// ============================================================================
interface fetch_queue_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              enable;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  count;

  // master: the fetch stage itself
  modport master (
    input  enable, imem_rdata, instr_ready, redirect, redirect_pc,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, count
  );

  // slave: memory, decode and control surrounding the fetch stage
  modport slave (
    output enable, imem_rdata, instr_ready, redirect, redirect_pc,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Brief    : Instruction fetch stage: owns the fetch PC, issues one-cycle
//             latency memory reads and buffers instr/PC pairs for decode.
//  Revision : 1.0
// ============================================================================
module fetch_queue #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] c_depth = (CNT_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem_instr [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc    [DEPTH];
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  logic              w_pop;
  logic              w_push;
  logic              w_req;
  logic [CNT_W:0]    w_used;

  assign w_pop  = bus.instr_valid & bus.instr_ready;
  assign w_push = r_inflight;

  // Credit check: slots already taken plus the word in flight, less the slot
  // freed this cycle, must leave room for the word this issue will return.
  assign w_used = {1'b0, r_count}
                + {{CNT_W{1'b0}}, r_inflight}
                - {{CNT_W{1'b0}}, w_pop};
  assign w_req  = bus.enable & ~bus.redirect & ~reset & (w_used < c_depth);

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = (r_count != '0);
  assign bus.instr       = r_mem_instr[r_rd_ptr];
  assign bus.instr_pc    = r_mem_pc[r_rd_ptr];
  assign bus.count       = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else if (bus.redirect) begin
      // The returning word belongs to the abandoned path and is dropped.
      r_fetch_pc <= bus.redirect_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_req) begin
        r_fetch_pc    <= r_fetch_pc + 1'b1;
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_fetch_pc;
      end else begin
        r_inflight <= 1'b0;
      end

      if (w_push) begin
        r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
        r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire
